// File: rtl/pb_defs.sv
// Shared definitions for the push-button debouncer: FSM state
// encoding, default timing parameters and a counter-width helper.
package pb_defs;

   typedef logic [1:0] state_t;

   localparam state_t IDLE         = 2'd0;
   localparam state_t PRESS_WAIT   = 2'd1;
   localparam state_t PRESSED      = 2'd2;
   localparam state_t RELEASE_WAIT = 2'd3;

   localparam int DEBOUNCE_CYCLES_DEF   = 4;
   localparam int LONG_PRESS_CYCLES_DEF = 10;

   // One spare bit so a counter can hold its terminal value safely.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit board input.
// Ports: clk, rst (sync, active high), d (async in), q (synchronized out).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pb_debounce_rx.sv
// Push-button debouncer with press/release/long-press strobes and LED toggle.
// Ports: clk, rst (sync, active high), btn_in (raw async button, 1 = pressed),
//        btn_level, press_pulse, release_pulse, long_press_pulse, led0.
module pb_debounce_rx
   import pb_defs::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse,
   output logic led0
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   logic          btn_sync;
   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] db_cnt;
   logic [HW-1:0] hold_cnt;
   logic          holding;
   logic          level_nxt;
   logic          press_nxt;
   logic          release_nxt;
   logic          long_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The sample that leaves IDLE/PRESSED is not counted; the wait
   // states count DEBOUNCE_CYCLES further agreeing samples.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (btn_sync) state_nxt = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!btn_sync)             state_nxt = IDLE;
            else if (db_cnt == DB_LAST) state_nxt = PRESSED;
         end
         PRESSED: begin
            if (!btn_sync) state_nxt = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (btn_sync)              state_nxt = PRESSED;
            else if (db_cnt == DB_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign holding = (state == PRESSED) || (state == RELEASE_WAIT);

   always_comb begin
      level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      press_nxt   = (state == PRESS_WAIT) && (state_nxt == PRESSED);
      release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
      long_nxt    = holding && (hold_cnt == HOLD_LAST);
   end

   // Counting only while staying in a wait state bounds db_cnt at DB_LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
      end else if ((state_nxt == state) &&
                   ((state == PRESS_WAIT) || (state == RELEASE_WAIT))) begin
         db_cnt <= db_cnt + DW'(1);
      end else begin
         db_cnt <= '0;
      end
   end

   // Release bounces keep the hold count running, so a long press
   // still fires once even if the button chatters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (press_nxt || (state == IDLE)) begin
         hold_cnt <= '0;
      end else if (holding && (hold_cnt != HOLD_MAX)) begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_level        <= 1'b0;
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;
         led0             <= 1'b0;
      end else begin
         btn_level        <= level_nxt;
         press_pulse      <= press_nxt;
         release_pulse    <= release_nxt;
         long_press_pulse <= long_nxt;
         led0             <= led0 ^ press_nxt;
      end
   end

endmodule

// File: tb/tb_pb_debounce_rx.sv
// Self-checking bench for pb_debounce_rx with default parameters.
// Expected event cycles are queued per kind and compared with observed ones.
module tb_pb_debounce_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press_pulse;
   logic led0;

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;
   logic led_prev;
   logic lvl_prev;
   logic led_exp = 1'b0;

   // kinds: 0 press, 1 release, 2 long, 3 led change, 4 level change
   int exp_q[5][$];
   int obs_q[5][$];
   string kname[5] = '{"press", "release", "long", "led", "level"};

   pb_debounce_rx #(
      .DEBOUNCE_CYCLES   (4),
      .LONG_PRESS_CYCLES (10)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .btn_in           (btn_in),
      .btn_level        (btn_level),
      .press_pulse      (press_pulse),
      .release_pulse    (release_pulse),
      .long_press_pulse (long_press_pulse),
      .led0             (led0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!mon_en) begin
         led_prev = led0;
         lvl_prev = btn_level;
      end else begin
         if (press_pulse === 1'b1)      obs_q[0].push_back(cyc);
         if (release_pulse === 1'b1)    obs_q[1].push_back(cyc);
         if (long_press_pulse === 1'b1) obs_q[2].push_back(cyc);
         if (led0 !== led_prev)         obs_q[3].push_back(cyc);
         if (btn_level !== lvl_prev)    obs_q[4].push_back(cyc);
         led_prev = led0;
         lvl_prev = btn_level;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_press(input int at);
      exp_q[0].push_back(at);
      exp_q[3].push_back(at);
      exp_q[4].push_back(at);
      led_exp = ~led_exp;
   endtask

   task automatic exp_release(input int at);
      exp_q[1].push_back(at);
      exp_q[4].push_back(at);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_in = 1'b0;
      tick(3);
      n_cmp++;
      if (btn_level !== 1'b0) begin
         n_fail++;
         $display("FAIL reset btn_level: got %b want 0", btn_level);
      end
      n_cmp++;
      if (press_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset press_pulse: got %b want 0", press_pulse);
      end
      n_cmp++;
      if (release_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset release_pulse: got %b want 0", release_pulse);
      end
      n_cmp++;
      if (long_press_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset long_press_pulse: got %b want 0", long_press_pulse);
      end
      n_cmp++;
      if (led0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset led0: got %b want 0", led0);
      end
      rst = 1'b0;
      tick(2);
      mon_en = 1'b1;
      tick(2);
   endtask

   task automatic test_bounce();
      int o, e;
      for (int i = 0; i < 5; i++) begin
         btn_in = 1'b1;
         tick(2);
         btn_in = 1'b0;
         tick(2);
      end
      tick(12);
      n_cmp++;
      if (btn_level !== 1'b0 || led0 !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce level/led: got %b/%b want 0/0", btn_level, led0);
      end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            n_fail++;
            $display("FAIL bounce %s count: got %0d want %0d",
                     kname[k], obs_q[k].size(), exp_q[k].size());
         end
         while (obs_q[k].size() > 0 && exp_q[k].size() > 0) begin
            o = obs_q[k].pop_front();
            e = exp_q[k].pop_front();
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL bounce %s cycle: got %0d want %0d", kname[k], o, e);
            end
         end
         obs_q[k].delete();
         exp_q[k].delete();
      end
   endtask

   task automatic test_clean_press();
      int n, m, o, e;
      n = cyc + 1;
      btn_in = 1'b1;
      exp_press(n + 6);
      exp_q[2].push_back(n + 16);
      tick(30);
      n_cmp++;
      if (btn_level !== 1'b1 || led0 !== 1'b1) begin
         n_fail++;
         $display("FAIL clean held level/led: got %b/%b want 1/1", btn_level, led0);
      end
      m = cyc + 1;
      btn_in = 1'b0;
      exp_release(m + 6);
      tick(12);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            n_fail++;
            $display("FAIL clean %s count: got %0d want %0d",
                     kname[k], obs_q[k].size(), exp_q[k].size());
         end
         while (obs_q[k].size() > 0 && exp_q[k].size() > 0) begin
            o = obs_q[k].pop_front();
            e = exp_q[k].pop_front();
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL clean %s cycle: got %0d want %0d", kname[k], o, e);
            end
         end
         obs_q[k].delete();
         exp_q[k].delete();
      end
   endtask

   task automatic test_release_glitch();
      int n, m, o, e;
      n = cyc + 1;
      btn_in = 1'b1;
      exp_press(n + 6);
      exp_q[2].push_back(n + 16);
      tick(10);
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      tick(6);
      n_cmp++;
      if (btn_level !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch btn_level: got %b want 1", btn_level);
      end
      tick(7);
      m = cyc + 1;
      btn_in = 1'b0;
      exp_release(m + 6);
      tick(12);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            n_fail++;
            $display("FAIL glitch %s count: got %0d want %0d",
                     kname[k], obs_q[k].size(), exp_q[k].size());
         end
         while (obs_q[k].size() > 0 && exp_q[k].size() > 0) begin
            o = obs_q[k].pop_front();
            e = exp_q[k].pop_front();
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL glitch %s cycle: got %0d want %0d", kname[k], o, e);
            end
         end
         obs_q[k].delete();
         exp_q[k].delete();
      end
   endtask

   task automatic test_reset_mid_press();
      int n, r, f, m, o, e;
      n = cyc + 1;
      btn_in = 1'b1;
      exp_press(n + 6);
      tick(9);
      r = cyc + 1;
      rst = 1'b1;
      if (led_exp) exp_q[3].push_back(r);
      led_exp = 1'b0;
      exp_q[4].push_back(r);
      tick(1);
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, long_press_pulse, led0} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid outputs: got %b%b%b%b%b want 00000", btn_level,
                  press_pulse, release_pulse, long_press_pulse, led0);
      end
      f = cyc + 1;
      rst = 1'b0;
      exp_press(f + 6);
      tick(8);
      m = cyc + 1;
      btn_in = 1'b0;
      exp_release(m + 6);
      tick(12);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            n_fail++;
            $display("FAIL rstmid %s count: got %0d want %0d",
                     kname[k], obs_q[k].size(), exp_q[k].size());
         end
         while (obs_q[k].size() > 0 && exp_q[k].size() > 0) begin
            o = obs_q[k].pop_front();
            e = exp_q[k].pop_front();
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL rstmid %s cycle: got %0d want %0d", kname[k], o, e);
            end
         end
         obs_q[k].delete();
         exp_q[k].delete();
      end
   endtask

   task automatic test_toggle();
      int n, m, o, e;
      logic want[3];
      want = '{1'b1, 1'b0, 1'b1};
      rst = 1'b1;
      if (led_exp) exp_q[3].push_back(cyc + 1);
      led_exp = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(3);
      for (int i = 0; i < 3; i++) begin
         n = cyc + 1;
         btn_in = 1'b1;
         exp_press(n + 6);
         tick(7);
         n_cmp++;
         if (led0 !== want[i]) begin
            n_fail++;
            $display("FAIL toggle led0 #%0d: got %b want %b", i, led0, want[i]);
         end
         tick(1);
         m = cyc + 1;
         btn_in = 1'b0;
         exp_release(m + 6);
         tick(12);
      end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            n_fail++;
            $display("FAIL toggle %s count: got %0d want %0d",
                     kname[k], obs_q[k].size(), exp_q[k].size());
         end
         while (obs_q[k].size() > 0 && exp_q[k].size() > 0) begin
            o = obs_q[k].pop_front();
            e = exp_q[k].pop_front();
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL toggle %s cycle: got %0d want %0d", kname[k], o, e);
            end
         end
         obs_q[k].delete();
         exp_q[k].delete();
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_clean_press();
      test_release_glitch();
      test_reset_mid_press();
      test_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
